// File: rtl/countdown_timer_ctrl.sv
// Countdown timer sequencer: loads a start value, decrements on a prescaled tick,
// and handles pause, abort, auto-reload and a one-cycle expiry pulse.
module countdown_timer_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  abort,
  input  logic                  reload,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  paused,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic [WIDTH-1:0]      sh_load_q, sh_load_d;
  logic [PRESCALE_W-1:0] sh_pre_q, sh_pre_d;
  logic                  sh_reload_q, sh_reload_d;
  logic                  busy_q, paused_q, done_q;
  logic                  tick_c;

  assign tick_c = (pre_q == sh_pre_q);

  // Next-state and datapath decisions
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    pre_d       = pre_q;
    sh_load_d   = sh_load_q;
    sh_pre_d    = sh_pre_q;
    sh_reload_d = sh_reload_q;

    unique case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (start) begin
          sh_load_d = load_val;
          sh_pre_d  = prescale;
          pre_d     = '0;
          if (load_val != '0) begin
            sh_reload_d = reload;
            count_d     = load_val;
            state_d     = ST_RUN;
          end else begin
            sh_reload_d = 1'b0;
            state_d     = ST_DONE;
          end
        end
      end

      // Leaving PAUSE counts as a productive cycle so each paused cycle costs one clock
      ST_RUN, ST_PAUSE: begin
        if (abort) begin
          state_d     = ST_IDLE;
          count_d     = '0;
          pre_d       = '0;
          sh_reload_d = 1'b0;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RUN;
          if (tick_c) begin
            pre_d = '0;
            if (count_q == WIDTH'(1)) begin
              count_d = '0;
              state_d = ST_DONE;
            end else if (count_q != '0) begin
              count_d = count_q - WIDTH'(1);
            end
          end else begin
            pre_d = pre_q + PRESCALE_W'(1);
          end
        end
      end

      ST_DONE: begin
        pre_d = '0;
        if (abort) begin
          state_d     = ST_IDLE;
          count_d     = '0;
          sh_reload_d = 1'b0;
        end else if (sh_reload_q) begin
          state_d = ST_RUN;
          count_d = sh_load_q;
        end else begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        count_d = '0;
        pre_d   = '0;
      end
    endcase
  end

  // State, datapath and registered status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      pre_q       <= '0;
      sh_load_q   <= '0;
      sh_pre_q    <= '0;
      sh_reload_q <= 1'b0;
      busy_q      <= 1'b0;
      paused_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pre_q       <= pre_d;
      sh_load_q   <= sh_load_d;
      sh_pre_q    <= sh_pre_d;
      sh_reload_q <= sh_reload_d;
      busy_q      <= (state_d == ST_RUN) || (state_d == ST_PAUSE);
      paused_q    <= (state_d == ST_PAUSE);
      done_q      <= (state_d == ST_DONE);
    end
  end

  assign count  = count_q;
  assign busy   = busy_q;
  assign paused = paused_q;
  assign done   = done_q;

endmodule

// File: doc/countdown_timer_ctrl.md
# countdown_timer_ctrl

Programmable countdown timer controller that sequences a down counter: it loads a start value, decrements it on a prescaled tick, supports pause, abort and auto-reload, and flags expiry with a single-cycle `done` pulse. It sits between a control master (register block or FSM) and the down-counter datapath, and owns every load, enable and terminal-count decision.

## Interface
- `WIDTH`, 8, counter width in bits
- `PRESCALE_W`, 4, prescaler width; each decrement takes `prescale`+1 clocks

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  start request; honoured only in IDLE
- `pause`  in  1  level; high holds the count while running
- `abort`  in  1  cancel; returns to IDLE without `done`
- `reload`  in  1  auto-reload enable, latched at start
- `load_val`  in  WIDTH  initial count, latched at start
- `prescale`  in  PRESCALE_W  tick divider, latched at start
- `count`  out  WIDTH  current count value
- `busy`  out  1  high in RUN or PAUSE
- `paused`  out  1  high in PAUSE
- `done`  out  1  one-cycle expiry pulse, high in DONE

## Operation
- Reset (`rst`=0, asynchronous): state IDLE; `count`, prescaler counter and shadow registers (load value, prescale, reload flag) cleared to 0; `busy`=`paused`=`done`=0.
- IDLE: `count` holds 0.
  - `start`=1, `load_val`≠0: latch `load_val`, `prescale` and `reload`; `count`←`load_val`; prescaler counter←0; go to RUN.
  - `start`=1, `load_val`=0: go to DONE with the latched reload flag forced to 0.
- RUN: prescaler counter increments each cycle. When it equals latched prescale, a tick occurs: prescaler←0 and `count`←`count`−1. A tick with `count`=1 makes `count` 0 and goes to DONE.
  - `pause`=1: go to PAUSE. No tick and no prescaler advance that cycle.
- PAUSE: `count` and prescaler frozen. `pause`=0 returns to RUN; the prescaler resumes from its held value.
- DONE: `done`=1 for exactly this cycle and `count`=0.
  - Latched reload=1: `count`←shadow load value, prescaler←0, go to RUN.
  - Otherwise: go to IDLE.
- `abort`=1 in RUN, PAUSE or DONE: next state IDLE, `count`←0, prescaler←0, shadow reload flag←0. In DONE, `done` stays high for that cycle.
- Priority: reset > `abort` > `pause` > tick.
- `start` is ignored outside IDLE. `load_val`, `prescale` and `reload` changes after start have no effect until the next start.
- Decrement never wraps: 0 is reached only via the DONE transition.

## Timing
- Outputs are registered/Moore: `busy`, `paused` and `done` are decoded from the state register only.
- The sequence below uses `prescale`=P and `load_val`=N≠0, with `start` sampled at edge 0.
  - After edge 0: `count`=N and `busy`=1.
  - Decrements occur at edges k·(P+1) for k=1..N.
  - At edge N·(P+1): `count`=0 and `done`=1 for one cycle.
  - At the next edge: IDLE (`busy`=0), or RUN with `count`=N.
- Auto-reload period is N·(P+1)+1 clocks between `done` pulses.
- Each pause cycle in RUN/PAUSE extends expiry by exactly one clock.
- `start` with `load_val`=0: `done` appears one cycle after the start edge, followed by IDLE.
- Reset mid-operation: outputs drop immediately (asynchronous). No `done` is generated.

## Test plan
- Basic run: reset, then `start` with N=5, P=0. Required: `count` reads 5,4,3,2,1,0 on consecutive cycles; `done` is high one cycle with `count`=0; next cycle IDLE, `busy`=0.
- Prescale: N=3, P=2. Required: decrements at edges 3, 6, 9; `done` during the cycle after edge 9; `count` stable for 3 clocks per value.
- Pause: N=4, P=0, `pause` high for 3 cycles while `count`=2. Required: `paused`=1 and `count` frozen at 2 for 3 cycles; `done` delayed exactly 3 cycles.
- Auto-reload: N=2, P=0, `reload`=1. Required: `done` pulses every 3 clocks and `count` cycles 2,1,0,2,1,0.
  - Then `abort`: required IDLE next cycle, `count`=0, no further `done`.
- Zero load and priority: `start` with N=0. Required: a single `done`, then IDLE with no reload.
  - Then `pause` and `abort` together in RUN: `abort` wins, `count`=0 next cycle.
- Asynchronous reset: assert `rst`=0 mid-cycle while RUN with `count`=6. Required: `count`=0 and `busy`=0 immediately without a clock edge; no `done` after release.
